reg_lock_scoreboard: RTL and testbench

//  Sequential, multi-issue successor to the combinational register-grant checker.
//  - Holds a per-register in-flight writer counter instead of a 1-bit lock.
//  - Grants up to NI in-order issue channels per cycle and releases locks on NWB writeback ports.
//  - Serialises blocking instructions through a drain/hold state machine.
//  - Sits between decode/issue and the execution-unit arbiter.

---
 rtl/rv64g_pkg.sv | 19 +
 rtl/reg_lock_cnt.sv | 49 ++++
 rtl/reg_lock_scoreboard.sv | 194 +++++++++++++++++++
 tb/tb_reg_lock_scoreboard.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64g_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv64g_pkg
// Brief    : Shared core types and sizes, including scoreboard state encoding.
// Revision : 1.0
// ============================================================================
package rv64g_pkg;

    localparam int NUM_REGS = 32;
    localparam int SB_CNT_W = 2;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_HOLD  = 2'd2
    } sb_state_e;

endpackage : rv64g_pkg
`default_nettype wire

// File: rtl/reg_lock_cnt.sv
`default_nettype none
// ============================================================================
// Module   : reg_lock_cnt
// Brief    : In-flight writer counter for one architectural register.
// Revision : 1.0
// ============================================================================
module reg_lock_cnt #(
    parameter int CNT_W = 2,
    parameter int INC_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt,
    output logic             saturated,
    output logic             nonzero,
    output logic             underflow
);

    localparam int SUM_W = CNT_W + INC_W + DEC_W;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_dec;

    // Writebacks in excess of the available writers are dropped and flagged.
    assign w_sum     = SUM_W'(r_cnt) + SUM_W'(inc);
    assign w_dec     = SUM_W'(dec);
    assign underflow = (w_dec > w_sum);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (underflow) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= CNT_W'(w_sum - w_dec);
        end
    end

    assign cnt       = r_cnt;
    assign saturated = &r_cnt;
    assign nonzero   = |r_cnt;

endmodule : reg_lock_cnt
`default_nettype wire

// File: rtl/reg_lock_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_lock_scoreboard
// Brief    : Multi-issue register scoreboard with counted locks and blocking
//            instruction serialisation.
// Revision : 1.0
// ============================================================================
module reg_lock_scoreboard
    import rv64g_pkg::*;
#(
    parameter int NR    = NUM_REGS,
    parameter int NI    = 2,
    parameter int NWB   = 2,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NI-1:0]           iss_valid_i,
    input  logic [NI-1:0]           iss_blocking_i,
    input  logic [NI*$clog2(NR)-1:0] iss_rd_i,
    input  logic [NI*NR-1:0]        iss_req_i,
    output logic [NI-1:0]           iss_gnt_o,
    input  logic [NWB-1:0]          wb_valid_i,
    input  logic [NWB*$clog2(NR)-1:0] wb_rd_i,
    input  logic                    blk_done_i,
    input  logic                    flush_i,
    output logic [NR-1:0]           locks_o,
    output logic                    busy_o,
    output logic                    underflow_o
);

    localparam int RW    = $clog2(NR);
    localparam int INC_W = $clog2(NI + 1);
    localparam int DEC_W = $clog2(NWB + 1);
    localparam int SAT_W = CNT_W + INC_W;
    localparam logic [SAT_W-1:0] c_cnt_max = SAT_W'((1 << CNT_W) - 1);

    sb_state_e        r_state;
    sb_state_e        w_state_next;
    logic             r_underflow;
    logic [CNT_W-1:0] w_cnt [NR];
    logic [INC_W-1:0] w_inc [NR];
    logic [DEC_W-1:0] w_dec [NR];
    logic [NR-1:0]    w_nonzero;
    logic [NR-1:0]    w_sat;
    logic [NR-1:0]    w_uf;
    logic [NI-1:0]    w_gnt;
    logic             w_blk_gnt;
    logic             w_all_zero;
    logic             w_ch0_blk;

    logic [NR-1:0]    w_pend;
    logic             w_in_order;
    logic             w_ok;
    logic             w_sat_ok;
    logic [RW-1:0]    w_rd_j;
    logic [RW-1:0]    w_rd_k;
    logic [NR-1:0]    w_req_j;
    logic [INC_W-1:0] w_same;

    assign w_all_zero = ~|w_nonzero;
    assign w_ch0_blk  = iss_valid_i[0] && iss_blocking_i[0];

    // In-order grant chain: a stalled channel stops every younger channel.
    always_comb begin
        w_gnt      = '0;
        w_blk_gnt  = 1'b0;
        w_pend     = '0;
        w_in_order = 1'b1;
        w_ok       = 1'b0;
        w_sat_ok   = 1'b0;
        w_rd_j     = '0;
        w_rd_k     = '0;
        w_req_j    = '0;
        w_same     = '0;
        for (int j = 0; j < NI; j++) begin
            w_rd_j  = iss_rd_i[j*RW +: RW];
            w_req_j = iss_req_i[j*NR +: NR];
            w_same  = '0;
            for (int k = 0; k < NI; k++) begin
                w_rd_k = iss_rd_i[k*RW +: RW];
                if ((k < j) && w_gnt[k] && (w_rd_k == w_rd_j)) begin
                    w_same = w_same + INC_W'(1);
                end
            end
            w_sat_ok = (w_same == '0) ? !w_sat[w_rd_j]
                     : ((SAT_W'(w_cnt[w_rd_j]) + SAT_W'(w_same)) < c_cnt_max);
            w_ok = iss_valid_i[j] && w_in_order && !flush_i;
            if (iss_blocking_i[j]) begin
                w_ok = w_ok && (j == 0) && w_all_zero &&
                       ((r_state == SB_RUN) || (r_state == SB_DRAIN));
            end else begin
                w_ok = w_ok && (r_state == SB_RUN) &&
                       ((w_req_j & (w_nonzero | w_pend)) == '0) && w_sat_ok;
            end
            w_gnt[j] = w_ok;
            if (w_ok && (w_rd_j != '0)) begin
                w_pend[w_rd_j] = 1'b1;
            end
            if (w_ok && iss_blocking_i[j]) begin
                w_blk_gnt = 1'b1;
            end
            w_in_order = w_ok && !iss_blocking_i[j];
        end
    end

    // x0 never counts; flushed writebacks are discarded entirely.
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            w_inc[r] = '0;
            w_dec[r] = '0;
            for (int j = 0; j < NI; j++) begin
                if (w_gnt[j] && (r != 0) && (iss_rd_i[j*RW +: RW] == RW'(r))) begin
                    w_inc[r] = w_inc[r] + INC_W'(1);
                end
            end
            for (int p = 0; p < NWB; p++) begin
                if (wb_valid_i[p] && !flush_i && (r != 0) &&
                    (wb_rd_i[p*RW +: RW] == RW'(r))) begin
                    w_dec[r] = w_dec[r] + DEC_W'(1);
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < NR; r++) begin : g_cnt
            reg_lock_cnt #(
                .CNT_W (CNT_W),
                .INC_W (INC_W),
                .DEC_W (DEC_W)
            ) u_cnt (
                .clk       (clk_i),
                .rst       (rst_i),
                .clr       (flush_i),
                .inc       (w_inc[r]),
                .dec       (w_dec[r]),
                .cnt       (w_cnt[r]),
                .saturated (w_sat[r]),
                .nonzero   (w_nonzero[r]),
                .underflow (w_uf[r])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SB_RUN: begin
                if (w_blk_gnt) begin
                    w_state_next = SB_HOLD;
                end else if (w_ch0_blk) begin
                    w_state_next = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                if (!w_ch0_blk) begin
                    w_state_next = SB_RUN;
                end else if (w_blk_gnt) begin
                    w_state_next = SB_HOLD;
                end
            end
            SB_HOLD: begin
                if (blk_done_i) begin
                    w_state_next = SB_RUN;
                end
            end
            default: w_state_next = SB_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= SB_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_underflow <= 1'b0;
        end else if (|w_uf) begin
            r_underflow <= 1'b1;
        end
    end

    assign iss_gnt_o   = w_gnt;
    assign locks_o     = w_nonzero;
    assign busy_o      = (|w_nonzero) || (r_state != SB_RUN);
    assign underflow_o = r_underflow;

endmodule : reg_lock_scoreboard
`default_nettype wire

// File: tb/tb_reg_lock_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_lock_scoreboard
// Brief    : Directed self-checking bench for reg_lock_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_reg_lock_scoreboard;

    localparam int NR  = 32;
    localparam int NI  = 2;
    localparam int NWB = 2;
    localparam int RW  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI-1:0]    iss_valid;
    logic [NI-1:0]    iss_blocking;
    logic [NI*RW-1:0] iss_rd;
    logic [NI*NR-1:0] iss_req;
    logic [NI-1:0]    iss_gnt;
    logic [NWB-1:0]   wb_valid;
    logic [NWB*RW-1:0] wb_rd;
    logic             blk_done;
    logic             flush;
    logic [NR-1:0]    locks;
    logic             busy;
    logic             underflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_lock_scoreboard #(
        .NR    (NR),
        .NI    (NI),
        .NWB   (NWB),
        .CNT_W (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .iss_valid_i    (iss_valid),
        .iss_blocking_i (iss_blocking),
        .iss_rd_i       (iss_rd),
        .iss_req_i      (iss_req),
        .iss_gnt_o      (iss_gnt),
        .wb_valid_i     (wb_valid),
        .wb_rd_i        (wb_rd),
        .blk_done_i     (blk_done),
        .flush_i        (flush),
        .locks_o        (locks),
        .busy_o         (busy),
        .underflow_o    (underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid    = '0;
        iss_blocking = '0;
        iss_rd       = '0;
        iss_req      = '0;
        wb_valid     = '0;
        wb_rd        = '0;
        blk_done     = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic drive_iss(input int ch, input logic blk, input logic [4:0] rd,
                             input logic [31:0] req);
        iss_valid[ch]           = 1'b1;
        iss_blocking[ch]        = blk;
        iss_rd[ch*RW +: RW]     = rd;
        iss_req[ch*NR +: NR]    = req;
    endtask

    task automatic drive_wb(input int p, input logic [4:0] rd);
        wb_valid[p]          = 1'b1;
        wb_rd[p*RW +: RW]    = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_locks", 64'(locks), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_underflow", 64'(underflow), 64'h0);
        check("reset_gnt", 64'(iss_gnt), 64'h0);

        // Source of ch1 is the rd granted to ch0 in the same cycle
        drive_iss(0, 1'b0, 5'd5, 32'h0);
        drive_iss(1, 1'b0, 5'd6, 32'h0000_0020);
        #1;
        check("raw_same_cycle_gnt", 64'(iss_gnt), 64'h1);
        step();
        idle();
        #1;
        check("lock_after_grant", 64'(locks), 64'h0000_0020);
        check("busy_after_grant", 64'(busy), 64'h1);
        drive_wb(0, 5'd5);
        step();
        idle();
        #1;
        check("unlock_after_wb", 64'(locks), 64'h0);

        // Independent dual grant, then a stall on a locked source
        drive_iss(0, 1'b0, 5'd1, 32'h0);
        drive_iss(1, 1'b0, 5'd2, 32'h0000_0008);
        #1;
        check("dual_gnt", 64'(iss_gnt), 64'h3);
        step();
        idle();
        drive_iss(0, 1'b0, 5'd8, 32'h0000_0002);
        drive_iss(1, 1'b0, 5'd9, 32'h0);
        #1;
        check("locks_dual", 64'(locks), 64'h0000_0006);
        check("stall_locked_src", 64'(iss_gnt), 64'h0);
        idle();
        drive_wb(0, 5'd1);
        drive_wb(1, 5'd2);
        step();
        idle();
        #1;
        check("dual_unlock", 64'(locks), 64'h0);

        // Same-cycle inc and dec on x7
        drive_iss(0, 1'b0, 5'd7, 32'h0);
        step();
        idle();
        drive_iss(0, 1'b0, 5'd7, 32'h0);
        drive_wb(0, 5'd7);
        #1;
        check("inc_dec_gnt", 64'(iss_gnt), 64'h1);
        step();
        idle();
        #1;
        check("inc_dec_lock", 64'(locks), 64'h0000_0080);
        drive_wb(0, 5'd7);
        step();
        idle();
        #1;
        check("inc_dec_net_one", 64'(locks), 64'h0);

        // Saturation on x3
        drive_iss(0, 1'b0, 5'd3, 32'h0);
        drive_iss(1, 1'b0, 5'd3, 32'h0);
        #1;
        check("sat_first_pair", 64'(iss_gnt), 64'h3);
        step();
        #1;
        check("sat_second_pair", 64'(iss_gnt), 64'h1);
        step();
        idle();
        drive_iss(0, 1'b0, 5'd3, 32'h0);
        #1;
        check("sat_stall", 64'(iss_gnt), 64'h0);
        drive_wb(0, 5'd3);
        #1;
        check("sat_wb_not_credited", 64'(iss_gnt), 64'h0);
        step();
        idle();
        drive_iss(0, 1'b0, 5'd3, 32'h0);
        #1;
        check("sat_after_wb", 64'(iss_gnt), 64'h1);
        step();
        idle();
        drive_wb(0, 5'd3);
        drive_wb(1, 5'd3);
        step();
        idle();
        #1;
        check("sat_partial_drain", 64'(locks), 64'h0000_0008);
        drive_wb(0, 5'd3);
        step();
        idle();
        #1;
        check("sat_drained", 64'(locks), 64'h0);
        check("no_underflow_yet", 64'(underflow), 64'h0);

        // Blocking instruction drains x9, holds, then releases
        drive_iss(0, 1'b0, 5'd9, 32'h0);
        step();
        idle();
        drive_iss(0, 1'b1, 5'd0, 32'h0);
        drive_iss(1, 1'b0, 5'd10, 32'h0);
        #1;
        check("blk_stall_run", 64'(iss_gnt), 64'h0);
        step();
        drive_wb(0, 5'd9);
        #1;
        check("blk_stall_drain", 64'(iss_gnt), 64'h0);
        step();
        wb_valid = '0;
        #1;
        check("blk_gnt_drain", 64'(iss_gnt), 64'h1);
        step();
        idle();
        drive_iss(0, 1'b0, 5'd11, 32'h0);
        #1;
        check("hold_no_gnt", 64'(iss_gnt), 64'h0);
        check("hold_busy", 64'(busy), 64'h1);
        blk_done = 1'b1;
        #1;
        check("hold_done_cycle_gnt", 64'(iss_gnt), 64'h0);
        step();
        blk_done = 1'b0;
        #1;
        check("run_after_done_busy", 64'(busy), 64'h0);
        check("run_after_done_gnt", 64'(iss_gnt), 64'h1);
        step();
        idle();
        drive_wb(0, 5'd11);
        step();
        idle();

        // Flush from DRAIN with x4 holding two writers
        drive_iss(0, 1'b0, 5'd4, 32'h0);
        drive_iss(1, 1'b0, 5'd4, 32'h0);
        step();
        idle();
        drive_iss(0, 1'b1, 5'd0, 32'h0);
        step();
        flush = 1'b1;
        drive_wb(0, 5'd4);
        drive_wb(1, 5'd4);
        #1;
        check("flush_gnt_forced", 64'(iss_gnt), 64'h0);
        step();
        idle();
        #1;
        check("flush_locks", 64'(locks), 64'h0);
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_wb_discarded", 64'(underflow), 64'h0);
        drive_iss(0, 1'b1, 5'd4, 32'h0);
        #1;
        check("blk_gnt_run", 64'(iss_gnt), 64'h1);
        step();
        idle();
        #1;
        check("hold_with_lock", 64'(locks), 64'h0000_0010);
        flush = 1'b1;
        step();
        idle();
        #1;
        check("flush_hold_busy", 64'(busy), 64'h0);

        // Underflow is sticky; x0 never locks
        drive_wb(0, 5'd12);
        step();
        idle();
        #1;
        check("underflow_set", 64'(underflow), 64'h1);
        drive_iss(0, 1'b0, 5'd0, 32'h0);
        #1;
        check("x0_gnt", 64'(iss_gnt), 64'h1);
        step();
        idle();
        #1;
        check("x0_no_lock", 64'(locks), 64'h0);
        check("underflow_sticky", 64'(underflow), 64'h1);
        flush = 1'b1;
        step();
        idle();
        #1;
        check("underflow_kept_flush", 64'(underflow), 64'h1);

        // Mid-operation reset
        drive_iss(0, 1'b0, 5'd13, 32'h0);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_locks", 64'(locks), 64'h0);
        check("midrst_underflow", 64'(underflow), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_lock_scoreboard
`default_nettype wire
